// File: rtl/cordic_prerotate.sv
// CORDIC input front end: sign-extends the raw x/y samples, pre-rotates by
// +/-pi/2 into the convergence range, and presents the result behind a
// 2-entry skid buffer so that in_ready comes straight from a flop.
module cordic_prerotate #(
  parameter int   DATA_W  = 18,
  parameter int   XYI     = 19,
  parameter int   ANGLE_W = 32,
  parameter logic MODE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic signed [ANGLE_W-1:0] z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [XYI:0]       x_out,
  output logic signed [XYI:0]       y_out,
  output logic signed [ANGLE_W-1:0] z_out,
  output logic [1:0]                quad_out
);

  localparam int XW = XYI + 1;
  localparam logic [ANGLE_W-1:0] HALF_PI = {2'b01, {(ANGLE_W-2){1'b0}}};

  // The datapath needs one guard bit so that negating the most-negative
  // sample cannot overflow.
  generate
    if (XW < DATA_W + 1) begin : g_width_check
      $error("cordic_prerotate: XYI+1 must be at least DATA_W+1");
    end
  endgenerate

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t state_r, state_nxt;

  logic in_ready_r;
  logic out_valid_r;

  logic [XW-1:0]      x_sx_s, y_sx_s;
  logic [XW-1:0]      pre_x_s, pre_y_s;
  logic [ANGLE_W-1:0] pre_z_s;
  logic [1:0]         pre_q_s;

  logic [XW-1:0]      main_x_r, main_y_r, skid_x_r, skid_y_r;
  logic [ANGLE_W-1:0] main_z_r, skid_z_r;
  logic [1:0]         main_q_r, skid_q_r;

  logic acc_s, pop_s;
  logic load_main_s, load_skid_s, move_skid_s;

  assign acc_s = in_valid & in_ready_r;
  assign pop_s = out_valid_r & out_ready;

  // Pre-rotation of the incoming sample, evaluated before it is captured.
  always_comb begin
    x_sx_s  = {{(XW-DATA_W){x_in[DATA_W-1]}}, x_in};
    y_sx_s  = {{(XW-DATA_W){y_in[DATA_W-1]}}, y_in};
    pre_x_s = x_sx_s;
    pre_y_s = y_sx_s;
    pre_z_s = z_in;
    pre_q_s = 2'b00;
    if (MODE == 1'b0) begin
      // Rotation: the two top angle bits give the quadrant of the target.
      case (z_in[ANGLE_W-1 -: 2])
        2'b01: begin
          pre_x_s = -y_sx_s;
          pre_y_s = x_sx_s;
          pre_z_s = z_in - HALF_PI;
          pre_q_s = 2'b01;
        end
        2'b10: begin
          pre_x_s = y_sx_s;
          pre_y_s = -x_sx_s;
          pre_z_s = z_in + HALF_PI;
          pre_q_s = 2'b10;
        end
        default: begin
          pre_x_s = x_sx_s;
          pre_y_s = y_sx_s;
          pre_z_s = z_in;
          pre_q_s = 2'b00;
        end
      endcase
    end else begin
      // Vectoring: only left-half-plane vectors need folding back.
      if (x_sx_s[XW-1]) begin
        if (y_sx_s[XW-1]) begin
          pre_x_s = -y_sx_s;
          pre_y_s = x_sx_s;
          pre_z_s = z_in - HALF_PI;
          pre_q_s = 2'b01;
        end else begin
          pre_x_s = y_sx_s;
          pre_y_s = -x_sx_s;
          pre_z_s = z_in + HALF_PI;
          pre_q_s = 2'b10;
        end
      end else begin
        pre_x_s = x_sx_s;
        pre_y_s = y_sx_s;
        pre_z_s = z_in;
        pre_q_s = 2'b00;
      end
    end
  end

  // Skid-buffer next state and register load strobes.
  always_comb begin
    state_nxt   = state_r;
    load_main_s = 1'b0;
    load_skid_s = 1'b0;
    move_skid_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (acc_s) begin
          state_nxt   = ONE;
          load_main_s = 1'b1;
        end else begin
          state_nxt = EMPTY;
        end
      end
      ONE: begin
        if (acc_s && !pop_s) begin
          state_nxt   = FULL;
          load_skid_s = 1'b1;
        end else if (acc_s && pop_s) begin
          state_nxt   = ONE;
          load_main_s = 1'b1;
        end else if (pop_s) begin
          state_nxt = EMPTY;
        end else begin
          state_nxt = ONE;
        end
      end
      FULL: begin
        if (pop_s) begin
          state_nxt   = ONE;
          move_skid_s = 1'b1;
        end else begin
          state_nxt = FULL;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Control state plus the registered handshake flags derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      in_ready_r  <= (state_nxt != FULL);
      out_valid_r <= (state_nxt != EMPTY);
    end
  end

  // Main (output) and skid data registers; reset discards buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_x_r <= '0;
      main_y_r <= '0;
      main_z_r <= '0;
      main_q_r <= 2'b00;
      skid_x_r <= '0;
      skid_y_r <= '0;
      skid_z_r <= '0;
      skid_q_r <= 2'b00;
    end else begin
      if (load_main_s) begin
        main_x_r <= pre_x_s;
        main_y_r <= pre_y_s;
        main_z_r <= pre_z_s;
        main_q_r <= pre_q_s;
      end else if (move_skid_s) begin
        main_x_r <= skid_x_r;
        main_y_r <= skid_y_r;
        main_z_r <= skid_z_r;
        main_q_r <= skid_q_r;
      end
      if (load_skid_s) begin
        skid_x_r <= pre_x_s;
        skid_y_r <= pre_y_s;
        skid_z_r <= pre_z_s;
        skid_q_r <= pre_q_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign x_out     = main_x_r;
  assign y_out     = main_y_r;
  assign z_out     = main_z_r;
  assign quad_out  = main_q_r;

endmodule

// File: tb/tb_cordic_prerotate.sv
// Bench for cordic_prerotate: a rotation-mode and a vectoring-mode instance
// share one stimulus stream; each has its own scoreboard queue of expected
// words, plus directed checks of the documented example vectors.
module tb_cordic_prerotate;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready;
  logic signed [17:0] x_in, y_in;
  logic signed [31:0] z_in;

  logic r_in_ready, r_out_valid, v_in_ready, v_out_valid;
  logic signed [19:0] r_x, r_y, v_x, v_y;
  logic signed [31:0] r_z, v_z;
  logic [1:0] r_q, v_q;

  int n_tests = 0;
  int n_fail  = 0;

  typedef logic [73:0] word_t;
  word_t q_rot[$];
  word_t q_vec[$];

  cordic_prerotate #(.DATA_W(18), .XYI(19), .ANGLE_W(32), .MODE(1'b0)) u_rot (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(r_out_valid),
    .out_ready(out_ready), .x_out(r_x), .y_out(r_y), .z_out(r_z), .quad_out(r_q)
  );

  cordic_prerotate #(.DATA_W(18), .XYI(19), .ANGLE_W(32), .MODE(1'b1)) u_vec (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(v_in_ready),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(v_out_valid),
    .out_ready(out_ready), .x_out(v_x), .y_out(v_y), .z_out(v_z), .quad_out(v_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pre-rotation, packed as {quad, z, y, x}.
  function automatic word_t model(input bit vec, input logic [17:0] x, input logic [17:0] y,
                                  input logic [31:0] z);
    logic signed [19:0] xs, ys, ex, ey;
    logic [31:0] ez;
    logic [1:0] eq;
    xs = $signed(x);
    ys = $signed(y);
    ex = xs; ey = ys; ez = z; eq = 2'b00;
    if (!vec) begin
      if (z[31:30] == 2'b01) begin
        ex = -ys; ey = xs; ez = z - 32'h4000_0000; eq = 2'b01;
      end else if (z[31:30] == 2'b10) begin
        ex = ys; ey = -xs; ez = z + 32'h4000_0000; eq = 2'b10;
      end
    end else if (xs < 0) begin
      if (ys >= 0) begin
        ex = ys; ey = -xs; ez = z + 32'h4000_0000; eq = 2'b10;
      end else begin
        ex = -ys; ey = xs; ez = z - 32'h4000_0000; eq = 2'b01;
      end
    end
    return {eq, ez, ey, ex};
  endfunction

  // Scoreboard: pop/compare on output transfers, push on input transfers.
  always @(negedge clk) begin
    if (rst) begin
      q_rot.delete();
      q_vec.delete();
    end else begin
      if (r_out_valid && out_ready) begin
        if (q_rot.size() == 0) check("rot_underflow", q_rot.size(), 1);
        else check("rot_word", {r_q, r_z, r_y, r_x}, q_rot.pop_front());
      end
      if (v_out_valid && out_ready) begin
        if (q_vec.size() == 0) check("vec_underflow", q_vec.size(), 1);
        else check("vec_word", {v_q, v_z, v_y, v_x}, q_vec.pop_front());
      end
      if (in_valid && r_in_ready) q_rot.push_back(model(1'b0, x_in, y_in, z_in));
      if (in_valid && v_in_ready) q_vec.push_back(model(1'b1, x_in, y_in, z_in));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send one sample into an empty buffer and check it one cycle later.
  task automatic directed(input logic [17:0] x, input logic [17:0] y, input logic [31:0] z,
                          input bit vec, input logic [19:0] ex, input logic [19:0] ey,
                          input logic [31:0] ez, input logic [1:0] eq);
    string pfx;
    pfx = vec ? "vec" : "rot";
    out_ready = 1'b1;
    x_in = x; y_in = y; z_in = z; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({pfx, "_valid"}, vec ? v_out_valid : r_out_valid, 1);
    check({pfx, "_x"}, vec ? {v_x} : {r_x}, ex);
    check({pfx, "_y"}, vec ? {v_y} : {r_y}, ey);
    check({pfx, "_z"}, vec ? {v_z} : {r_z}, ez);
    check({pfx, "_quad"}, vec ? {v_q} : {r_q}, eq);
    step();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && (q_rot.size() != 0 || q_vec.size() != 0); i++) step();
    step();
    check("drain_rot", q_rot.size(), 0);
    check("drain_vec", q_vec.size(), 0);
    check("drain_valid", r_out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc_cnt, pop_cnt, val;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    step(); step();
    rst = 1'b0;
    check("rst_valid", r_out_valid, 0);
    check("rst_ready", r_in_ready, 1);
    check("rst_x", {r_x}, 0);
    check("rst_q", {r_q}, 0);

    // Documented example vectors.
    directed(18'h10000, 18'h00000, 32'h6000_0000, 1'b0, 20'h00000, 20'h10000, 32'h2000_0000, 2'b01);
    directed(18'h20000, 18'h00007, 32'h8000_0000, 1'b0, 20'h00007, 20'h20000, 32'hC000_0000, 2'b10);
    directed(18'h00005, 18'h00006, 32'h3FFF_FFFF, 1'b0, 20'h00005, 20'h00006, 32'h3FFF_FFFF, 2'b00);
    directed(18'h3FC18, 18'h001F4, 32'h0000_0000, 1'b1, 20'h001F4, 20'h003E8, 32'h4000_0000, 2'b10);
    directed(18'h3FC18, 18'h3FE0C, 32'h0000_0000, 1'b1, 20'h001F4, 20'hFFC18, 32'hC000_0000, 2'b01);
    directed(18'h00000, 18'h3FFFB, 32'h0000_0000, 1'b1, 20'h00000, 20'hFFFFB, 32'h0000_0000, 2'b00);
    drain();

    // Backpressure: out_ready low for 4 cycles, then released.
    out_ready = 1'b0; in_valid = 1'b1; val = 1; acc_cnt = 0; pop_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) begin
        check("bp_accepted", acc_cnt, 2);
        check("bp_in_ready", r_in_ready, 0);
        out_ready = 1'b1;
        acc_cnt = 0;
      end
      x_in = 18'(val); y_in = 18'(val); z_in = 32'($urandom);
      @(negedge clk);
      if (in_valid && r_in_ready) begin
        val++;
        if (c >= 7) acc_cnt++;
      end else if (c < 4) begin
        acc_cnt = acc_cnt + 0;
      end
      if (c < 4 && in_valid && r_in_ready) acc_cnt++;
      if (c >= 7 && r_out_valid && out_ready) pop_cnt++;
      step();
    end
    check("steady_accepts", acc_cnt, 17);
    check("steady_pops", pop_cnt, 17);
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      x_in = 18'($urandom); y_in = 18'($urandom); z_in = 32'($urandom);
      if ($urandom_range(0, 9) == 0) x_in = 18'h20000;
      if ($urandom_range(0, 9) == 0) y_in = 18'h20000;
      step();
    end
    drain();

    // Reset while FULL.
    out_ready = 1'b0; in_valid = 1'b1;
    x_in = 18'd11; y_in = 18'd12; z_in = 32'h5000_0000;
    step();
    x_in = 18'd13;
    step();
    in_valid = 1'b0;
    check("full_in_ready", r_in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstfull_valid", r_out_valid, 0);
    check("rstfull_ready", r_in_ready, 1);
    check("rstfull_vec_valid", v_out_valid, 0);
    check("rstfull_data", {r_q, r_z, r_y, r_x}, 0);
    directed(18'd77, 18'd3, 32'h0000_0000, 1'b0, 20'd77, 20'd3, 32'h0000_0000, 2'b00);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_prerotate.md
Name: cordic_prerotate

Overview:
- Input-side front end of the CORDIC pipeline. Sits directly upstream of iteration stage 0 and drives its x/y/z inputs.
- Sign-extends the raw samples to the pipeline datapath width, then pre-rotates by ±π/2 so the vector or angle lands inside the CORDIC convergence range (±~99.9°).
- Provides a valid/ready boundary through a 2-entry skid buffer, so in_ready is a pure register output.
- Emits a quadrant tag that travels alongside the data for downstream bookkeeping.

Parameters:
- DATA_W, 18, width of the signed raw x/y input samples.
- XYI, 19, MSB index of the internal x/y datapath, so the datapath is XYI+1 bits. Must satisfy XYI+1 >= DATA_W+1; elaboration error otherwise.
- ANGLE_W, 32, angle width. Full scale 2^ANGLE_W = 2π, so π/2 = 2^(ANGLE_W-2).
- MODE, 1'b0, 0 = rotation, 1 = vectoring. Must match the MODE of the stages it feeds.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  input sample valid.
- in_ready  output  1  block can accept a sample this cycle; registered.
- x_in  input  DATA_W  signed x sample.
- y_in  input  DATA_W  signed y sample.
- z_in  input  ANGLE_W  signed angle. Rotation: target angle. Vectoring: initial accumulator, normally 0.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the output word.
- x_out  output  XYI+1  signed pre-rotated x.
- y_out  output  XYI+1  signed pre-rotated y.
- z_out  output  ANGLE_W  signed corrected angle.
- quad_out  output  2  pre-rotation applied: 00 none, 01 +π/2, 10 −π/2.

Behaviour:
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Once out_valid is asserted, x_out, y_out, z_out and quad_out hold stable until the word is transferred.
- Sign extension: x_in and y_in are sign-extended to XYI+1 bits before any arithmetic. Negation is exact; the most-negative DATA_W input never overflows.
- Rotation mode (MODE=0), case selected by z_in[ANGLE_W-1:ANGLE_W-2]:
  - 00 or 11: pass through unchanged; quad=00.
  - 01: x' = −y, y' = x, z' = z − π/2; quad=01.
  - 10: x' = y, y' = −x, z' = z + π/2; quad=10.
- Vectoring mode (MODE=1):
  - x >= 0: pass through unchanged; quad=00.
  - x < 0 and y >= 0: x' = y, y' = −x, z' = z + π/2; quad=10.
  - x < 0 and y < 0: x' = −y, y' = x, z' = z − π/2; quad=01.
- Angle arithmetic is modulo 2^ANGLE_W (wraps, no saturation).
- Pre-rotation is computed combinationally on the input side. The result is captured into a main register or a skid register.
- State machine, with per-state outputs:
  - EMPTY: out_valid=0.
  - ONE: main register valid, out_valid=1.
  - FULL: main and skid registers both valid, out_valid=1.
- Transitions (acc = input transfer, pop = output transfer):
  - EMPTY: acc → ONE (load main).
  - ONE: acc & !pop → FULL (load skid). acc & pop → ONE (reload main). !acc & pop → EMPTY. Otherwise hold.
  - FULL: pop → ONE (skid moves to main). Otherwise hold. No acceptance is possible in FULL.
- in_ready is registered: it is 1 in the cycle after the state becomes EMPTY or ONE, and 0 in the cycle after it becomes FULL.
- Latency: one cycle from input transfer to out_valid when EMPTY. Throughput is one word per cycle while out_ready=1.
- Ordering is strictly FIFO. No sample is lost or duplicated under any backpressure pattern.
- Reset (at power-up or mid-operation, including in FULL):
  - Next edge forces state EMPTY, out_valid=0, in_ready=1.
  - x_out, y_out, z_out, quad_out = 0.
  - Any buffered data is discarded.
- in_valid while in_ready=0 is ignored (no capture).

Test Plan:
- Rotation, x_in=65536, y_in=0, z_in=0x6000_0000 (135°) → one cycle later out_valid=1, x_out=0, y_out=65536, z_out=0x2000_0000, quad_out=01.
- Rotation, x_in=−131072, y_in=7, z_in=0x8000_0000 (−π) → x_out=7, y_out=+131072 (20-bit, no overflow), z_out=0xC000_0000, quad_out=10. A z_in=0x3FFF_FFFF sample → passed through, quad_out=00.
- Vectoring, z_in=0:
  - (x=−1000, y=500) → x_out=500, y_out=1000, z_out=0x4000_0000, quad_out=10.
  - (x=−1000, y=−500) → x_out=500, y_out=−1000, z_out=0xC000_0000, quad_out=01.
  - (x=0, y=−5) → unchanged, quad_out=00.
- Backpressure: in_valid=1 with incrementing samples 1,2,3,…, out_ready=0 for 4 cycles then 1 → exactly 2 samples accepted, then in_ready=0. After release, outputs appear in order 1,2,3,… with no gaps or duplicates. Steady state gives one word per cycle.
- Simultaneous accept and pop in ONE (in_valid=1, out_ready=1 continuously) → state stays ONE, in_ready stays 1, each sample appears exactly one cycle after acceptance.
- Reset in FULL → next cycle out_valid=0, in_ready=1, all data outputs 0. The first post-reset sample appears with one-cycle latency and no stale data.
